// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared constants and state types for the int_ctrl interrupt controller
package int_ctrl_pkg;

  localparam logic [15:0] CMD_ADDR     = 16'h0020;
  localparam logic [15:0] DATA_ADDR    = 16'h0021;

  localparam logic [7:0]  CMD_EOI      = 8'h20;
  localparam logic [7:0]  CMD_SEL_IRR  = 8'h0A;
  localparam logic [7:0]  CMD_SEL_ISR  = 8'h0B;

  localparam int          INIT_BIT     = 4;
  localparam logic [4:0]  BASE_DEFAULT = 5'b00001;

  typedef enum logic {DLV_IDLE, DLV_PEND}   dlv_state_t;
  typedef enum logic {CFG_NORMAL, CFG_INIT} cfg_state_t;
  typedef enum logic {SEL_IRR, SEL_ISR}     rd_sel_t;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - 8-bit priority encoder, bit 0 has the highest priority
module int_prio_enc (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - priority interrupt controller with I/O port and toggle handshake
// Define INT_CTRL_LEVEL_EN for level-triggered IRR instead of rising-edge capture.
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  irq_in,
  input  logic [15:0] port_addr,
  input  logic        port_clk,
  input  logic        port_w,
  input  logic [7:0]  port_wdata,
  output logic [7:0]  port_rdata,
  output logic [7:0]  vector,
  output logic        intr,
  input  logic        intl
);

  logic [7:0] irq_s1, irq_s2;
  logic [7:0] irr, imr, isr;
  logic [4:0] base;
  rd_sel_t    rd_sel;
  logic       port_clk_q;

  dlv_state_t dlv_state, dlv_next;
  cfg_state_t cfg_state, cfg_next;

  logic access, cmd_wr, cmd_rd, data_wr, data_rd, init_wr, eoi_wr;
  logic [7:0] pend_req;
  logic [2:0] pend_idx, isr_idx;
  logic       pend_valid, isr_valid;
  logic       start;
  logic [7:0] start_mask, eoi_mask;

  assign access  = port_clk & ~port_clk_q;
  assign cmd_wr  = access &&  port_w && (port_addr == CMD_ADDR);
  assign cmd_rd  = access && !port_w && (port_addr == CMD_ADDR);
  assign data_wr = access &&  port_w && (port_addr == DATA_ADDR);
  assign data_rd = access && !port_w && (port_addr == DATA_ADDR);
  assign init_wr = cmd_wr && port_wdata[INIT_BIT];
  assign eoi_wr  = cmd_wr && (port_wdata == CMD_EOI);

  assign pend_req = irr & ~imr;

  int_prio_enc u_pend_enc (
    .req   (pend_req),
    .idx   (pend_idx),
    .valid (pend_valid)
  );

  int_prio_enc u_isr_enc (
    .req   (isr),
    .idx   (isr_idx),
    .valid (isr_valid)
  );

  // Only a line strictly above the highest in-service level may preempt.
  assign start = (dlv_state == DLV_IDLE) && (intr == intl) && pend_valid &&
                 (!isr_valid || (pend_idx < isr_idx));

  assign start_mask = start ? (8'd1 << pend_idx) : 8'd0;
  assign eoi_mask   = (eoi_wr && isr_valid) ? (8'd1 << isr_idx) : 8'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dlv_state <= DLV_IDLE;
      cfg_state <= CFG_NORMAL;
    end else begin
      dlv_state <= dlv_next;
      cfg_state <= cfg_next;
    end
  end

  always_comb begin
    dlv_next = dlv_state;
    case (dlv_state)
      DLV_IDLE: if (start) dlv_next = DLV_PEND;
      DLV_PEND: if (intl == intr) dlv_next = DLV_IDLE;
      default:  dlv_next = DLV_IDLE;
    endcase
  end

  always_comb begin
    cfg_next = cfg_state;
    case (cfg_state)
      CFG_NORMAL: if (init_wr) cfg_next = CFG_INIT;
      CFG_INIT:   if (init_wr) cfg_next = CFG_INIT;
                  else if (data_wr) cfg_next = CFG_NORMAL;
      default:    cfg_next = CFG_NORMAL;
    endcase
  end

`ifdef INT_CTRL_LEVEL_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irr <= 8'd0;
    end else begin
      irr <= irq_s2;
    end
  end
`else
  logic [7:0] irq_prev;

  // A fresh edge on the line being delivered survives the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_prev <= 8'd0;
      irr      <= 8'd0;
    end else begin
      irq_prev <= irq_s2;
      irr      <= (irr & ~start_mask) | (irq_s2 & ~irq_prev);
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_s1     <= 8'd0;
      irq_s2     <= 8'd0;
      port_clk_q <= 1'b0;
      imr        <= 8'd0;
      isr        <= 8'd0;
      base       <= BASE_DEFAULT;
      rd_sel     <= SEL_IRR;
      port_rdata <= 8'd0;
      vector     <= 8'd0;
      intr       <= 1'b0;
    end else begin
      irq_s1     <= irq_in;
      irq_s2     <= irq_s1;
      port_clk_q <= port_clk;

      if (init_wr)
        imr <= 8'd0;
      else if (data_wr && (cfg_state == CFG_NORMAL))
        imr <= port_wdata;

      isr <= (init_wr ? 8'd0 : (isr & ~eoi_mask)) | start_mask;

      if (data_wr && (cfg_state == CFG_INIT))
        base <= port_wdata[7:3];

      if (cmd_wr && !port_wdata[INIT_BIT]) begin
        if (port_wdata == CMD_SEL_IRR)
          rd_sel <= SEL_IRR;
        else if (port_wdata == CMD_SEL_ISR)
          rd_sel <= SEL_ISR;
      end

      if (cmd_rd)
        port_rdata <= (rd_sel == SEL_ISR) ? isr : irr;
      else if (data_rd)
        port_rdata <= imr;

      if (start) begin
        vector <= {base, pend_idx};
        intr   <= ~intr;
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl; INT_CTRL_LEVEL_EN adds the level-mode scenario
module tb_int_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_in = 8'd0;
  logic [15:0] port_addr = 16'd0;
  logic        port_clk = 1'b0;
  logic        port_w = 1'b0;
  logic [7:0]  port_wdata = 8'd0;
  logic [7:0]  port_rdata;
  logic [7:0]  vector;
  logic        intr;
  logic        intl = 1'b0;

  int   n_vec = 0;
  int   n_bad = 0;
  logic tb_intr = 1'b0;

  int_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .irq_in     (irq_in),
    .port_addr  (port_addr),
    .port_clk   (port_clk),
    .port_w     (port_w),
    .port_wdata (port_wdata),
    .port_rdata (port_rdata),
    .vector     (vector),
    .intr       (intr),
    .intl       (intl)
  );

  always #5 clock = ~clock;

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic port_write(input logic [15:0] addr, input logic [7:0] data);
    @(posedge clock); #1;
    port_addr = addr; port_w = 1'b1; port_wdata = data; port_clk = 1'b1;
    @(posedge clock); #1;
    port_clk = 1'b0; port_w = 1'b0;
  endtask

  task automatic port_read(input logic [15:0] addr, output logic [7:0] data);
    @(posedge clock); #1;
    port_addr = addr; port_w = 1'b0; port_clk = 1'b1;
    @(posedge clock); #1;
    port_clk = 1'b0;
    data = port_rdata;
  endtask

  task automatic ack();
    @(posedge clock); #1;
    intl = ~intl;
  endtask

  task automatic wait_intr(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (intr === tb_intr) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    idle(2);
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL reset_intr: got %b want 0", intr); end
    n_vec++; if (vector !== 8'h00) begin n_bad++; $display("FAIL reset_vector: got %h want 00", vector); end
    n_vec++; if (port_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", port_rdata); end
    reset = 1'b0;
    idle(1);
    port_read(16'h0020, d);
    n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_irr: got %h want 00", d); end
    port_read(16'h0021, d);
    n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_imr: got %h want 00", d); end
  endtask

  task automatic test_basic();
    bit found;
    logic [7:0] d;
    found = 1'b0;
    @(posedge clock); #1;
    irq_in = 8'h08;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock); #1;
      if (i == 2) irq_in = 8'h00;
      if (intr === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tb_intr = 1'b1;
    n_vec++; if (!found) begin n_bad++; $display("FAIL basic_latency: got intr %b want 1 within 4 cycles", intr); end
    n_vec++; if (vector !== 8'h0B) begin n_bad++; $display("FAIL basic_vector: got %h want 0b", vector); end
    idle(6);
    n_vec++; if (vector !== 8'h0B || intr !== tb_intr) begin n_bad++; $display("FAIL basic_hold: got %h/%b want 0b/%b", vector, intr, tb_intr); end
    ack();
    port_write(16'h0020, 8'h20);
    port_write(16'h0020, 8'h0B);
    port_read(16'h0020, d);
    n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL basic_isr_eoi: got %h want 00", d); end
    port_write(16'h0020, 8'h0A);
  endtask

  task automatic test_priority();
    bit ok;
    logic [7:0] d;
    @(posedge clock); #1;
    irq_in = 8'h24;
    tb_intr = ~tb_intr;
    wait_intr(10, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL prio_first_timeout: got intr %b want %b", intr, tb_intr); end
    n_vec++; if (vector !== 8'h0A) begin n_bad++; $display("FAIL prio_first_vector: got %h want 0a", vector); end
    irq_in = 8'h20;
    ack();
    idle(8);
    n_vec++; if (intr !== tb_intr || vector !== 8'h0A) begin n_bad++; $display("FAIL prio_blocked: got %h/%b want 0a/%b", vector, intr, tb_intr); end
    port_write(16'h0020, 8'h0B);
    port_read(16'h0020, d);
    n_vec++; if (d !== 8'h04) begin n_bad++; $display("FAIL prio_isr: got %h want 04", d); end
    port_write(16'h0020, 8'h0A);
    port_read(16'h0020, d);
    n_vec++; if (d !== 8'h20) begin n_bad++; $display("FAIL prio_irr: got %h want 20", d); end
    port_write(16'h0020, 8'h20);
    tb_intr = ~tb_intr;
    wait_intr(10, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL prio_second_timeout: got intr %b want %b", intr, tb_intr); end
    n_vec++; if (vector !== 8'h0D) begin n_bad++; $display("FAIL prio_second_vector: got %h want 0d", vector); end
    irq_in = 8'h00;
    ack();
    port_write(16'h0020, 8'h20);
  endtask

  task automatic test_mask();
    bit ok;
    logic [7:0] d;
    port_write(16'h0021, 8'h08);
    irq_in = 8'h08;
    idle(8);
    n_vec++; if (intr !== tb_intr) begin n_bad++; $display("FAIL mask_no_delivery: got intr %b want %b", intr, tb_intr); end
    port_read(16'h0020, d);
    n_vec++; if (d !== 8'h08) begin n_bad++; $display("FAIL mask_irr: got %h want 08", d); end
    port_read(16'h0030, d);
    n_vec++; if (d !== 8'h08) begin n_bad++; $display("FAIL mask_bad_addr_read: got %h want 08", d); end
    port_write(16'h0022, 8'hFF);
    port_read(16'h0021, d);
    n_vec++; if (d !== 8'h08) begin n_bad++; $display("FAIL mask_bad_addr_write: got %h want 08", d); end
    port_write(16'h0021, 8'h00);
    tb_intr = ~tb_intr;
    wait_intr(10, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL mask_unmask_timeout: got intr %b want %b", intr, tb_intr); end
    n_vec++; if (vector !== 8'h0B) begin n_bad++; $display("FAIL mask_vector: got %h want 0b", vector); end
    irq_in = 8'h00;
    ack();
    port_write(16'h0020, 8'h20);
  endtask

  task automatic test_init();
    bit ok;
    logic [7:0] d;
    port_write(16'h0021, 8'h40);
    port_write(16'h0020, 8'h11);
    port_read(16'h0021, d);
    n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL init_imr_clear: got %h want 00", d); end
    port_write(16'h0021, 8'h70);
    port_read(16'h0021, d);
    n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL init_imr_kept: got %h want 00", d); end
    irq_in = 8'h02;
    tb_intr = ~tb_intr;
    wait_intr(10, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL init_timeout: got intr %b want %b", intr, tb_intr); end
    n_vec++; if (vector !== 8'h71) begin n_bad++; $display("FAIL init_vector: got %h want 71", vector); end
    irq_in = 8'h00;
    ack();
    port_write(16'h0020, 8'h20);
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] d;
    port_write(16'h0021, 8'h40);
`ifdef INT_CTRL_LEVEL_EN
    irq_in = 8'h40;
    idle(6);
`else
    for (int k = 0; k < 2; k++) begin
      irq_in = 8'h40;
      idle(3);
      irq_in = 8'h00;
      idle(3);
    end
`endif
    port_read(16'h0020, d);
    n_vec++; if (d !== 8'h40) begin n_bad++; $display("FAIL b2b_merged_irr: got %h want 40", d); end
    port_write(16'h0021, 8'h00);
    tb_intr = ~tb_intr;
    wait_intr(10, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got intr %b want %b", intr, tb_intr); end
    n_vec++; if (vector !== 8'h76) begin n_bad++; $display("FAIL b2b_vector: got %h want 76", vector); end
    irq_in = 8'h00;
    ack();
    port_write(16'h0020, 8'h20);
    idle(8);
    n_vec++; if (intr !== tb_intr) begin n_bad++; $display("FAIL b2b_single: got intr %b want %b", intr, tb_intr); end
    port_read(16'h0020, d);
    n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL b2b_irr_empty: got %h want 00", d); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] d;
    irq_in = 8'h10;
    tb_intr = ~tb_intr;
    wait_intr(10, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL rmid_timeout: got intr %b want %b", intr, tb_intr); end
    n_vec++; if (vector !== 8'h74) begin n_bad++; $display("FAIL rmid_vector: got %h want 74", vector); end
    irq_in = 8'h00;
    #2 reset = 1'b1;
    #1;
    tb_intr = 1'b0;
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL rmid_intr: got %b want 0", intr); end
    n_vec++; if (vector !== 8'h00) begin n_bad++; $display("FAIL rmid_vec_clr: got %h want 00", vector); end
    intl = 1'b1;
    idle(2);
    reset = 1'b0;
    port_write(16'h0020, 8'h0B);
    port_read(16'h0020, d);
    n_vec++; if (d !== 8'h00) begin n_bad++; $display("FAIL rmid_isr: got %h want 00", d); end
    port_write(16'h0020, 8'h0A);
    irq_in = 8'h04;
    idle(8);
    n_vec++; if (intr !== 1'b0) begin n_bad++; $display("FAIL rmid_wait_intl: got intr %b want 0", intr); end
    intl = 1'b0;
    tb_intr = 1'b1;
    wait_intr(10, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL rmid_resume_timeout: got intr %b want 1", intr); end
    n_vec++; if (vector !== 8'h0A) begin n_bad++; $display("FAIL rmid_resume_vector: got %h want 0a", vector); end
    irq_in = 8'h00;
    ack();
    port_write(16'h0020, 8'h20);
  endtask

`ifdef INT_CTRL_LEVEL_EN
  task automatic test_level();
    bit ok;
    irq_in = 8'h01;
    for (int k = 0; k < 3; k++) begin
      tb_intr = ~tb_intr;
      wait_intr(10, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL level_timeout_%0d: got intr %b want %b", k, intr, tb_intr); end
      n_vec++; if (vector !== 8'h08) begin n_bad++; $display("FAIL level_vector_%0d: got %h want 08", k, vector); end
      ack();
      idle(6);
      n_vec++; if (intr !== tb_intr) begin n_bad++; $display("FAIL level_held_%0d: got intr %b want %b", k, intr, tb_intr); end
      if (k == 2) irq_in = 8'h00;
      port_write(16'h0020, 8'h20);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_init();
    test_back_to_back();
    test_reset_mid();
`ifdef INT_CTRL_LEVEL_EN
    test_level();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have port clock, input, 1: system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port irq_in, input, 8: device request lines; line 0 has the highest priority.
REQ-004 SHALL have port port_addr, input, 16: I/O address driven by the core.
REQ-005 SHALL have port port_clk, input, 1: access strobe; an access occurs on the cycle a 0->1 transition is detected.
REQ-006 SHALL have port port_w, input, 1: high at the access strobe means write, low means read.
REQ-007 SHALL have port port_wdata, input, 8: write data.
REQ-008 SHALL have port port_rdata, output, 8: registered read data, held until the next read access.
REQ-009 SHALL have port vector, output, 8: interrupt vector presented to the core irq input.
REQ-010 SHALL have port intr, output, 1: request toggle; a request is outstanding while intr != intl.
REQ-011 SHALL have port intl, input, 1: core acknowledge toggle.

Function
REQ-012 SHALL pass each irq_in line through a two-flop synchroniser before any use.
REQ-013 SHALL hold registers IRR[7:0], IMR[7:0], ISR[7:0] and BASE[7:3]; BASE defaults to 5'b00001, giving vector 0x08.
REQ-014 SHALL set IRR bit n on a synchronised rising edge of line n; an edge while the bit is already set merges into that bit.
REQ-015 SHALL decode only addresses 0x0020 (CMD) and 0x0021 (DATA); other addresses are ignored and port_rdata is unchanged.
REQ-016 SHALL treat a CMD write of 0x20 as non-specific EOI: clear the highest-priority set ISR bit; no effect if ISR = 0.
REQ-017 SHALL treat a CMD write of 0x0A as selecting IRR for CMD reads, and 0x0B as selecting ISR; IRR is selected after reset.
REQ-018 SHALL treat a CMD write with bit 4 set as starting init: clear IMR and ISR, then enter INIT.
REQ-019 SHALL, in INIT, load BASE from wdata[7:3] on the next DATA write and return to NORMAL.
REQ-020 SHALL, in NORMAL, treat a DATA write as an IMR write; a DATA read returns IMR.
REQ-021 SHALL run the delivery FSM states IDLE and PEND.
REQ-022 SHALL, in IDLE, start delivery when all hold: intr == intl; (IRR & ~IMR) != 0; and its highest-priority line n is strictly higher than the highest set ISR bit.
REQ-023 SHALL, on the delivery-start cycle, clear IRR[n], set ISR[n], latch vector = {BASE, n}, toggle intr, and enter PEND; the one-cycle latency is measured from IRR set.
REQ-024 SHALL, in PEND, hold vector and intr stable and return to IDLE on the first cycle intl == intr.
REQ-025 SHALL leave a delivery already in PEND unaffected by IMR or EOI writes made during PEND.
REQ-026 SHALL apply both effects in the same cycle when an EOI and a new edge coincide; the freed line is eligible the following cycle.
REQ-027 SHALL let an edge arriving during the set-IRR-to-delivery cycle on a lower-priority line remain in IRR.
REQ-028 SHALL wait without delivering when intl != intr while in IDLE (for example after reset, since the core does not reset intl), until intl == intr.

Reset
REQ-029 SHALL clear, on reset asserted, IRR, ISR, IMR, synchronisers, edge history, intr, port_rdata and vector to 0.
REQ-030 SHALL, on reset asserted, set BASE to 5'b00001, set the FSMs to IDLE and NORMAL, and select IRR for reads.
REQ-031 SHALL abandon a delivery in PEND without restoring the ISR bit when reset asserts mid-delivery.

Configuration
REQ-032 SHALL, when macro INT_CTRL_LEVEL_EN is defined, compute IRR each cycle as the synchronised irq_in level (level-triggered); an IRR bit delivered then cleared re-asserts while its line stays high.
REQ-033 SHALL, when INT_CTRL_LEVEL_EN is undefined, use the rising-edge capture of REQ-014 only.

Structure
REQ-034 SHALL place in package int_ctrl_pkg: the port addresses 0x0020/0x0021, the command codes 0x20/0x0A/0x0B, the init bit position, the default BASE, and the FSM state enums.
REQ-035 SHALL put the 8-bit priority encoder (index plus valid flag) in sub-module int_prio_enc, instantiated twice: once for IRR & ~IMR, once for ISR.

Verification
REQ-036 SHALL cover: reset, then an irq_in[3] pulse -> vector = 0x0B and intr toggles within 4 cycles; holding intl unchanged keeps vector stable.
REQ-037 SHALL cover: irq_in[5] and irq_in[2] rising in the same cycle -> 0x0A is delivered first; 0x0D follows only after EOI (CMD write 0x20) and an intl toggle.
REQ-038 SHALL cover: IMR = 0x08, then an irq_in[3] edge -> no delivery and IRR read = 0x08; after IMR = 0x00 -> vector 0x0B.
REQ-039 SHALL cover: CMD write 0x11, then DATA write 0x70, then an irq_in[1] edge -> vector = 0x71; the init write leaves IMR = 0.
REQ-040 SHALL cover: reset asserted during PEND -> intr = 0 and ISR = 0 immediately; after release with intl = 1, no delivery until intl returns to 0.
REQ-041 SHALL cover, with INT_CTRL_LEVEL_EN: irq_in[0] held high -> vector 0x08 is delivered, then re-delivered after each EOI plus acknowledge.
